// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one word request at a time, a fixed
// number of wait states, then a one-cycle ACK carrying read data or an error.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        WR,
  input  logic [0:31] ADDR,
  input  logic [0:31] WDATA,
  input  logic [0:3]  BE,
  output logic        ACK,
  output logic [0:31] RDATA,
  output logic        ERR,
  output logic        BUSY
);

  // state | meaning
  // IDLE  | waiting for REQ; request fields latched on acceptance
  // WAIT  | counting wait states; REQ low aborts without ACK or write
  // RESP  | ACK pulse cycle; store already committed on entry
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [0:31] addr_q;
  logic [0:31] wdata_q;
  logic [0:3]  be_q;
  logic [0:31] mem [2**DEPTH_LOG2];

  logic                  cur_wr;
  logic [0:31]           cur_addr;
  logic [0:31]           cur_wdata;
  logic [0:3]            cur_be;
  logic                  cur_err;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic                  enter_resp;

  // With zero wait states the response is formed from the live request on the
  // accepting edge; otherwise from the values latched at acceptance.
  always_comb begin
    cur_wr    = wr_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_be    = be_q;
    if (state == IDLE) begin
      cur_wr    = WR;
      cur_addr  = ADDR;
      cur_wdata = WDATA;
      cur_be    = BE;
    end
    cur_err    = (cur_addr[30:31] != 2'b00) || ((cur_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    cur_idx    = cur_addr[30-DEPTH_LOG2:29];
    enter_resp = ((state == IDLE) && REQ && (WAIT_CYCLES == 0)) ||
                 ((state == WAIT) && REQ && (cnt == 4'd0));
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ACK     <= 1'b0;
      ERR     <= 1'b0;
      RDATA   <= '0;
      BUSY    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      ACK   <= 1'b0;
      ERR   <= 1'b0;
      RDATA <= '0;
      case (state)
        IDLE: begin
          if (REQ) begin
            wr_q    <= WR;
            addr_q  <= ADDR;
            wdata_q <= WDATA;
            be_q    <= BE;
            state   <= WAIT;
            cnt     <= 4'(WAIT_CYCLES - 1);
            BUSY    <= 1'b1;
          end
        end
        WAIT: begin
          if (!REQ) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase

      if (enter_resp) begin
        state <= RESP;
        BUSY  <= 1'b1;
        ACK   <= 1'b1;
        ERR   <= cur_err;
        if (!cur_err) begin
          if (cur_wr) begin
            for (int i = 0; i < 4; i++) begin
              if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
          end else begin
            RDATA <= mem[cur_idx];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a byte-level memory model feeds a
// scoreboard queue, compared at each ACK; two instances cover 2 and 0 wait states.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req, wr, req0, wr0;
  logic [0:31] addr, wdata, addr0, wdata0;
  logic [0:3]  be, be0;
  logic        ack, err, busy, ack0, err0, busy0;
  logic [0:31] rdata, rdata0;

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_dut (
    .CLOCK(clk), .RESET(rst), .REQ(req), .WR(wr), .ADDR(addr), .WDATA(wdata),
    .BE(be), .ACK(ack), .RDATA(rdata), .ERR(err), .BUSY(busy));

  dmem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
    .CLOCK(clk), .RESET(rst), .REQ(req0), .WR(wr0), .ADDR(addr0), .WDATA(wdata0),
    .BE(be0), .ACK(ack0), .RDATA(rdata0), .ERR(err0), .BUSY(busy0));

  typedef struct {
    logic        err;
    logic [0:31] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [0:31] model[int];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(string tag, logic [0:31] obs, logic [0:31] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ack(bit sel);
    return sel ? ack0 : ack;
  endfunction
  function automatic logic get_err(bit sel);
    return sel ? err0 : err;
  endfunction
  function automatic logic get_busy(bit sel);
    return sel ? busy0 : busy;
  endfunction
  function automatic logic [0:31] get_rdata(bit sel);
    return sel ? rdata0 : rdata;
  endfunction

  task automatic drive(bit sel, logic r, logic w, logic [0:31] a, logic [0:31] d, logic [0:3] b);
    if (sel) begin
      req0 = r; wr0 = w; addr0 = a; wdata0 = d; be0 = b;
    end else begin
      req = r; wr = w; addr = a; wdata = d; be = b;
    end
  endtask

  // Expected response from the model; stores update the model here.
  function automatic exp_t predict(bit sel, bit w, logic [0:31] a, logic [0:31] d, logic [0:3] b);
    exp_t        e;
    logic [0:31] word;
    int          key;
    e.err   = (a[30:31] != 2'b00) || (a > 32'h0000_0FFF);
    e.rdata = '0;
    key     = int'(a) + (sel ? 32'h0001_0000 : 0);
    if (!e.err) begin
      word = model.exists(key) ? model[key] : 32'h0;
      if (w) begin
        for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = d[8*i +: 8];
        model[key] = word;
      end else begin
        e.rdata = word;
      end
    end
    return e;
  endfunction

  task automatic access(bit sel, bit w, logic [0:31] a, logic [0:31] d, logic [0:3] b,
                        bit change_addr = 1'b0);
    exp_t e;
    int   lat;
    bit   got;
    sb.push_back(predict(sel, w, a, d, b));
    @(negedge clk);
    drive(sel, 1'b1, w, a, d, b);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (change_addr && lat == 1) begin
        addr  = a ^ 32'h30;
        wdata = ~d;
      end
      if (get_ack(sel)) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), sel ? 32'd1 : 32'd3);
    e = sb.pop_front();
    if (got) begin
      chk("err", 32'(get_err(sel)), 32'(e.err));
      chk("rdata", get_rdata(sel), e.rdata);
      chk("busy_resp", 32'(get_busy(sel)), 32'd1);
    end
    drive(sel, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk);
    #1;
    chk("ack_pulse", 32'(get_ack(sel)), 32'd0);
    chk("err_idle", 32'(get_err(sel)), 32'd0);
    chk("rdata_idle", get_rdata(sel), 32'h0);
    chk("busy_idle", 32'(get_busy(sel)), 32'd0);
  endtask

  logic [0:31] bb_addr[4];
  int          edges;

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // full store/load, partial byte merge, BE=0, latched address
    access(0, 1, 32'h10, 32'hDEADBEEF, 4'b1111);
    access(0, 0, 32'h10, '0, 4'b0000);
    access(0, 1, 32'h10, 32'h11223344, 4'b0101);
    access(0, 0, 32'h10, '0, 4'b1111);
    chk("merge_model", model[32'h10], 32'hDE22BE44);
    access(0, 1, 32'h20, 32'h13579BDF, 4'b1111);
    access(0, 0, 32'h10, '0, 4'b0000, 1'b1);
    access(0, 1, 32'h20, 32'hFFFFFFFF, 4'b0000);
    access(0, 0, 32'h20, '0, 4'b0000);

    // errors
    access(0, 0, 32'h12, '0, 4'b0000);
    access(0, 1, 32'h0, 32'hA5A5A5A5, 4'b1111);
    access(0, 1, 32'h1000, 32'hFFFFFFFF, 4'b1111);
    access(0, 0, 32'h0, '0, 4'b0000);

    // abort after one WAIT cycle
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h20, 32'h0BADBAD0, 4'b1111);
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("abort_noack1", 32'(ack), 32'd0);
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("abort_noack", 32'(ack), 32'd0);
      chk("abort_busy_low", 32'(busy), 32'd0);
    end
    access(0, 0, 32'h20, '0, 4'b0000);

    // reset mid-transaction
    access(0, 1, 32'h40, 32'h77777777, 4'b1111);
    access(0, 1, 32'h44, 32'h600DF00D, 4'b1111);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'b1111);
    @(posedge clk);
    #1;
    chk("rstmid_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstmid_ack", 32'(ack), 32'd0);
    chk("rstmid_err", 32'(err), 32'd0);
    chk("rstmid_rdata", rdata, 32'h0);
    chk("rstmid_busy0", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rstmid_noack", 32'(ack), 32'd0);
    end
    access(0, 0, 32'h40, '0, 4'b0000);
    access(0, 0, 32'h44, '0, 4'b0000);

    // zero wait states, back-to-back loads with REQ held
    bb_addr[0] = 32'h0;
    bb_addr[1] = 32'h4;
    bb_addr[2] = 32'h8;
    bb_addr[3] = 32'h3FC;
    access(1, 1, bb_addr[0], 32'h01020304, 4'b1111);
    access(1, 1, bb_addr[1], 32'hA0B0C0D0, 4'b1111);
    access(1, 1, bb_addr[2], 32'h55AA55AA, 4'b1111);
    access(1, 1, bb_addr[3], 32'hFEEDFACE, 4'b1111);
    for (int i = 0; i < 4; i++) sb.push_back(predict(1, 0, bb_addr[i], '0, 4'b0000));
    @(negedge clk);
    drive(1, 1'b1, 1'b0, bb_addr[0], '0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      edges = 0;
      while (edges < 10) begin
        @(posedge clk);
        #1;
        edges++;
        if (ack0) break;
      end
      chk("bb_ack_seen", 32'(ack0), 32'd1);
      chk("bb_spacing", 32'(edges), (i == 0) ? 32'd1 : 32'd2);
      e = sb.pop_front();
      chk("bb_rdata", rdata0, e.rdata);
      chk("bb_err", 32'(err0), 32'(e.err));
      if (i < 3) addr0 = bb_addr[i+1];
      else req0 = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("bb_end_ack", 32'(ack0), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
